alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 40 ++++
 rtl/alu_mc_muldiv.sv | 110 +++++++++++
 rtl/alu_mc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and op-group decode.
// The DIV state exists only when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } op_e;

`ifdef ALU_MC_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
`endif

   function automatic logic is_mul(input op_e f);
      return f inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic is_div(input op_e f);
      return f inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative radix-2 shift-add multiplier and restoring divider, one bit per cycle.
// The divider path is present only when ALU_MC_DIV_EN is defined.
module alu_mc_muldiv
   import alu_mc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  op_e             op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   logic              busy_q;
   logic [CW-1:0]     cnt_q;
   op_e               op_q;
   logic              neg_q;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic              sa, sb;
   logic [XLEN-1:0]   ma, mb;
   logic [2*XLEN-1:0] prod;
`ifdef ALU_MC_DIV_EN
   logic              div_q, negr_q, dz_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN:0]     rem_sh, diff;
   logic [XLEN-1:0]   quo, rem;
`endif

   always_comb begin
      sa = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
      sb = (op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
      ma = sa ? -a : a;
      mb = sb ? -b : b;
   end

   // mcand holds the multiplicand (or divisor), mplier the multiplier (or dividend/quotient)
   always_comb begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
`ifdef ALU_MC_DIV_EN
      rem_sh = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
      diff   = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
      if (div_q) begin
         acc_d    = {{(XLEN-1){1'b0}}, diff[XLEN] ? rem_sh : diff};
         mcand_d  = mcand_q;
         mplier_d = {mplier_q[XLEN-2:0], ~diff[XLEN]};
      end
`endif
   end

   // Final value is formed from the last iteration's next-state so it is ready on done
   always_comb begin
      prod   = neg_q ? -acc_d : acc_d;
      result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_MC_DIV_EN
      quo = neg_q ? -mplier_d : mplier_d;
      rem = negr_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
      if (dz_q) begin
         quo = '1;
         rem = a_q;
      end
      if (div_q) result = (op_q inside {OP_DIV, OP_DIVU}) ? quo : rem;
`endif
   end

   assign done = busy_q && (cnt_q == CW'(XLEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         cnt_q <= cnt_q + CW'(1);
         if (done) busy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         op_q     <= op;
         neg_q    <= sa ^ sb;
         acc_q    <= '0;
         mcand_q  <= {{XLEN{1'b0}}, mb};
         mplier_q <= ma;
`ifdef ALU_MC_DIV_EN
         div_q    <= is_div(op);
         negr_q   <= sa;
         dz_q     <= (b == '0);
         a_q      <= a;
`endif
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32M/RV64M-style ALU with valid/ready handshake.
// Divide ops are built only when ALU_MC_DIV_EN is defined; otherwise they report err.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int OUT_REG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            err
);

   localparam int SW = $clog2(XLEN);

   function automatic logic [XLEN-1:0] alu_single(input op_e f, input logic [XLEN-1:0] x,
                                                   input logic [XLEN-1:0] y);
      logic [SW-1:0] sh;
      sh = y[SW-1:0];
      case (f)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         OP_SLL:  return x << sh;
         OP_SRL:  return x >> sh;
         OP_SRA:  return XLEN'($signed(x) >>> sh);
         OP_SLT:  return XLEN'($signed(x) < $signed(y));
         OP_SLTU: return XLEN'(x < y);
         default: return '0;
      endcase
   endfunction

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            err_q, err_d;
   op_e             op_c;
   logic            mul_req, div_req, undef_req;
   logic [XLEN-1:0] sc_res;
   logic            accept, comb_vld, md_start, md_done;
   logic [XLEN-1:0] md_result;

   assign op_c      = op_e'(op);
   assign mul_req   = is_mul(op_c);
`ifdef ALU_MC_DIV_EN
   assign div_req   = is_div(op_c);
`else
   assign div_req   = 1'b0;
`endif
   assign undef_req = !(op_c inside {[OP_ADD:OP_SLTU]}) && !mul_req && !div_req;
   assign sc_res    = alu_single(op_c, a, b);
   assign accept    = in_valid && in_ready;
   assign md_start  = accept && (mul_req || div_req);
   // Unregistered single-cycle results are offered straight from IDLE
   assign comb_vld  = (OUT_REG == 0) && (state_q == S_IDLE) && in_valid && !mul_req && !div_req;

   alu_mc_muldiv #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .op     (op_c),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .result (md_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (mul_req) begin
                  state_d = S_MUL;
`ifdef ALU_MC_DIV_EN
               end else if (div_req) begin
                  state_d = S_DIV;
`endif
               end else begin
                  result_d = sc_res;
                  zero_d   = (sc_res == '0);
                  err_d    = undef_req;
                  state_d  = (comb_vld && out_ready) ? S_IDLE : S_DONE;
               end
            end else if ((state_q == S_DONE) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            if (md_done) begin
               state_d  = S_DONE;
               result_d = md_result;
               zero_d   = (md_result == '0);
               err_d    = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
      out_valid = (state_q == S_DONE) || comb_vld;
      result    = comb_vld ? sc_res : result_q;
      zero      = comb_vld ? (sc_res == '0) : zero_q;
      err       = comb_vld ? undef_req : err_q;
   end

endmodule
